// File: rtl/threefish_round.sv
// threefish_round: iterative Threefish-1024 round, one MIX pair per cycle followed by
// the word permutation. Revision 1.0
`default_nettype none

module threefish_round (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [2:0]    d_i,
  input  logic [1023:0] state_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [1023:0] state_o
);

  typedef enum logic [0:0] {IDLE = 1'b0, MIX = 1'b1} fsm_t;

  // Output word i takes mixed word PERM[4i+3:4i].
  localparam logic [63:0] PERM = {4'd1, 4'd8, 4'd5, 4'd14, 4'd3, 4'd12, 4'd7, 4'd10,
                                  4'd15, 4'd4, 4'd11, 4'd6, 4'd13, 4'd2, 4'd9, 4'd0};

  fsm_t        fsm;
  logic [63:0] work  [16];
  logic [63:0] mixed [16];
  logic [2:0]  d;
  logic [2:0]  j;
  logic [63:0] x0, x1, y0, y1;
  logic [5:0]  rot;

  // One 48-bit row per d, six bits per j with j=0 in the low bits.
  function automatic logic [5:0] rot_amt(input logic [2:0] dd, input logic [2:0] jj);
    logic [47:0] row;
    case (dd)
      3'd0:    row = {6'd37, 6'd22, 6'd17, 6'd8,  6'd47, 6'd8,  6'd13, 6'd24};
      3'd1:    row = {6'd52, 6'd23, 6'd18, 6'd49, 6'd55, 6'd10, 6'd19, 6'd38};
      3'd2:    row = {6'd17, 6'd59, 6'd41, 6'd34, 6'd13, 6'd51, 6'd4,  6'd33};
      3'd3:    row = {6'd25, 6'd16, 6'd28, 6'd47, 6'd41, 6'd48, 6'd20, 6'd5};
      3'd4:    row = {6'd30, 6'd44, 6'd47, 6'd12, 6'd31, 6'd37, 6'd9,  6'd41};
      3'd5:    row = {6'd41, 6'd42, 6'd53, 6'd4,  6'd51, 6'd56, 6'd34, 6'd16};
      3'd6:    row = {6'd25, 6'd44, 6'd42, 6'd19, 6'd46, 6'd47, 6'd44, 6'd31};
      default: row = {6'd20, 6'd37, 6'd31, 6'd23, 6'd52, 6'd35, 6'd48, 6'd9};
    endcase
    return row[jj*6 +: 6];
  endfunction

  always_comb begin
    x0  = work[{j, 1'b0}];
    x1  = work[{j, 1'b1}];
    rot = rot_amt(d, j);
    y0  = x0 + x1;
    // Rotation amounts are never zero, so the right shift is always below 64.
    y1  = ((x1 << rot) | (x1 >> (7'd64 - {1'b0, rot}))) ^ y0;
    for (int i = 0; i < 16; i++) mixed[i] = work[i];
    mixed[14] = y0;
    mixed[15] = y1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm     <= IDLE;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      state_o <= '0;
      d       <= '0;
      j       <= '0;
      for (int i = 0; i < 16; i++) work[i] <= '0;
    end else begin
      done_o <= 1'b0;
      case (fsm)
        IDLE: begin
          if (start_i) begin
            for (int i = 0; i < 16; i++) work[i] <= state_i[64*i +: 64];
            d      <= d_i;
            j      <= '0;
            busy_o <= 1'b1;
            fsm    <= MIX;
          end
        end
        default: begin
          work[{j, 1'b0}] <= y0;
          work[{j, 1'b1}] <= y1;
          j <= j + 3'd1;
          if (j == 3'd7) begin
            for (int i = 0; i < 16; i++) state_o[64*i +: 64] <= mixed[PERM[4*i +: 4]];
            done_o <= 1'b1;
            busy_o <= 1'b0;
            fsm    <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_threefish_round.sv
// tb_threefish_round: directed vectors with hand-computed results for threefish_round.
// Revision 1.0
`default_nettype none

module tb_threefish_round;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    d = '0;
  logic [1023:0] st_in = '0;
  logic          busy, done;
  logic [1023:0] st_out;

  int checks = 0;
  int errors = 0;
  int overlap = 0;

  threefish_round dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .d_i(d),
    .state_i(st_in), .busy_o(busy), .done_o(done), .state_o(st_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (busy && done) overlap++;

  task automatic check_eq(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1023:0] wd(input int k, input logic [63:0] v);
    logic [1023:0] t;
    t = '0;
    t[64*k +: 64] = v;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a start that the next edge accepts, then scrambles the inputs.
  task automatic start_round(input logic [2:0] dv, input logic [1023:0] sv);
    start = 1'b1;
    d     = dv;
    st_in = sv;
    tick();
    start = 1'b0;
    d     = 3'd5;
    st_in = {32{32'hDEADBEEF}};
  endtask

  task automatic wait_done(output int n, output int bc);
    n  = 0;
    bc = 0;
    for (int k = 1; k <= 20; k++) begin
      if (busy) bc++;
      tick();
      n = k;
      if (done) break;
    end
  endtask

  logic [1023:0] exp_zero, exp_first, exp_last, exp_wrap;
  logic [1023:0] in_first, in_last, in_wrap;
  int n, bc, nd, first;

  initial begin
    in_first  = wd(1, 64'h1);
    exp_first = wd(0, 64'h1) | wd(15, 64'h0000000001000001);
    in_last   = wd(15, 64'h1);
    exp_last  = wd(12, 64'h1) | wd(7, 64'h0000000000100001);
    in_wrap   = wd(0, 64'hFFFFFFFFFFFFFFFF) | wd(1, 64'h1);
    exp_wrap  = wd(15, 64'h0000000001000000);
    exp_zero  = '0;

    // Reset held with start asserted: reset wins.
    start = 1'b1;
    st_in = in_first;
    tick();
    tick();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_state", st_out, exp_zero);
    rst   = 1'b0;
    start = 1'b0;
    tick();
    check_eq("post_rst_idle", busy, 0);

    start_round(3'd0, '0);
    wait_done(n, bc);
    check_eq("zero_lat", n, 8);
    check_eq("zero_state", st_out, exp_zero);

    start_round(3'd0, in_first);
    wait_done(n, bc);
    check_eq("first_lat", n, 8);
    check_eq("first_busy_cycles", bc, 8);
    check_eq("first_done", done, 1);
    check_eq("first_busy_at_done", busy, 0);
    check_eq("first_state", st_out, exp_first);
    tick();
    check_eq("done_one_cycle", done, 0);
    check_eq("state_hold", st_out, exp_first);

    start_round(3'd7, in_last);
    wait_done(n, bc);
    check_eq("last_lat", n, 8);
    check_eq("last_state", st_out, exp_last);

    start_round(3'd0, in_wrap);
    wait_done(n, bc);
    check_eq("wrap_state", st_out, exp_wrap);

    // Extra start pulse sampled at E3 must be ignored.
    start_round(3'd0, in_first);
    tick();
    tick();
    start = 1'b1;
    st_in = in_last;
    d     = 3'd7;
    tick();
    start = 1'b0;
    nd = 0;
    first = -1;
    for (int k = 1; k <= 15; k++) begin
      if (done) begin
        nd++;
        if (first < 0) first = k + 2;
      end
      tick();
    end
    check_eq("ignore_done_count", nd, 1);
    check_eq("ignore_done_edge", first, 8);
    check_eq("ignore_state", st_out, exp_first);

    // Back-to-back: start during the done cycle.
    start_round(3'd0, in_wrap);
    wait_done(n, bc);
    check_eq("b2b_a_state", st_out, exp_wrap);
    start = 1'b1;
    d     = 3'd7;
    st_in = in_last;
    tick();
    start = 1'b0;
    check_eq("b2b_accepted", busy, 1);
    check_eq("b2b_hold", st_out, exp_wrap);
    wait_done(n, bc);
    check_eq("b2b_spacing", n + 1, 9);
    check_eq("b2b_b_state", st_out, exp_last);

    // Reset sampled at E4 aborts the round.
    start_round(3'd0, in_wrap);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_state", st_out, exp_zero);
    rst = 1'b0;
    nd = 0;
    for (int k = 0; k < 12; k++) begin
      if (done) nd++;
      tick();
    end
    check_eq("abort_no_done", nd, 0);
    start_round(3'd0, in_first);
    wait_done(n, bc);
    check_eq("abort_fresh_lat", n, 8);
    check_eq("abort_fresh_state", st_out, exp_first);

    check_eq("busy_done_overlap", overlap, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/threefish_round.md
# threefish_round

Iterative Threefish-1024 round engine for the Skein hash core. It sits directly upstream of the output state register and is the consumer of the `rotator` block. It takes a 1024-bit state, applies the eight MIX operations of one round one pair per cycle through a single 64-bit adder, `rotator` and XOR datapath, then applies the Threefish-1024 word permutation. A start/busy/done handshake lets the round controller sequence 80 rounds plus key injections around it.

## Interface
Parameters: none. Word width is fixed at 64 and the word count at 16.

- clk_i  input  1  system clock; all state updates on rising edge
- rst_i  input  1  reset; one clock, synchronous, active-high
- start_i  input  1  request one round; sampled only while busy_o=0
- d_i  input  3  round index mod 8; selects the rotation constant set; captured on accepted start
- state_i  input  1024  input state; word k = state_i[64k+63:64k]; captured on accepted start
- busy_o  output  1  high while a round is in progress
- done_o  output  1  single-cycle pulse; state_o is valid and updated in this cycle
- state_o  output  1024  registered permuted result, same word packing as state_i; holds until the next done_o

## Operation
- FSM states: IDLE and MIX. The j counter is 3 bits.
- IDLE, start_i=1 on an edge:
  - capture state_i into the work register and d_i into the d register
  - set j=0 and go to MIX
- IDLE, start_i=0: no change.
- MIX, each edge performs pair j:
  - x0 = work[2j], x1 = work[2j+1]
  - y0 = (x0 + x1) mod 2^64; carry out is discarded
  - y1 = rotator(x1, d, j) XOR y0, where `rotator` performs ROTL by R[d][j]
  - write y0 to work[2j] and y1 to work[2j+1]
  - j <= j+1
- MIX with j=7:
  - form mixed = work with words 14 and 15 replaced by y0 and y1
  - state_o[word i] <= mixed[π(i)], with π = 0,9,2,13,6,11,4,15,10,7,12,3,14,5,8,1
  - done_o <= 1, go to IDLE, j wraps to 0
- start_i during MIX is ignored and not queued.
- Reset values: busy_o=0, done_o=0, state_o=0, work=0, d=0, j=0, FSM=IDLE.
- rst_i mid-round aborts the round. The result is discarded, no done_o is produced, and the engine is in IDLE on the next cycle.
- rst_i and start_i asserted on the same edge: reset wins and the start is dropped.

## Timing
- Start accepted at edge E0. busy_o=1 from E0 through E8; MIX pairs j=0..7 complete at edges E1..E8.
- state_o update and done_o=1 occur at E8. done_o is high for exactly one cycle; busy_o=0 in that same cycle.
- Latency: 8 cycles from the accepting edge to visible result.
- Back-to-back operation: start_i high during the done_o cycle is accepted at E9.
  - Throughput is one round per 9 cycles.
  - state_o keeps the prior result until the next E8.
- done_o and busy_o are never both high.
- state_i and d_i may change freely after the accepting edge.
- Critical path: one 64-bit add, the rotator mux, one XOR, and the writeback mux.

## Test plan
- Reset: hold rst_i for 2 cycles with start_i=1 → busy_o=0, done_o=0, state_o=0. A later start with all-zero state_i and d_i=0 → done_o 8 cycles after the accept, state_o=0.
- Single word, first pair: d_i=0, word1=1, all other words 0.
  - Required: out[0]=0x1, out[15]=0x0000000001000001, all other words 0.
  - busy_o is high for exactly 8 cycles before done_o.
- Last pair and permutation: d_i=7, word15=1, all other words 0.
  - Required: out[12]=0x1, out[7]=0x0000000000100001, all other words 0.
- Adder wrap: d_i=0, word0=0xFFFFFFFFFFFFFFFF, word1=1, all other words 0.
  - Required: out[0]=0, out[15]=0x0000000001000000, all other words 0.
- Handshake:
  - Pulse start_i again at E3 → it is ignored and exactly one done_o occurs.
  - Assert start_i in the done_o cycle → it is accepted, and the second done_o comes 9 cycles after the first.
  - Check that done_o and busy_o are never high together.
- Reset mid-round: assert rst_i at E4 → no done_o, state_o=0, busy_o=0 next cycle. A fresh start afterwards produces the correct result for the single-word, first-pair vector.
